// File: rtl/gcd_host_driver_if.sv
// Interface bundling the requester handshake and the GCD Processor
// handshake seen by gcd_host_driver.
//   start/op_x/op_y          : request strobe and operand pair
//   busy/result/result_valid : request status and returned GCD
//   error/timeout            : one-cycle failure pulses
//   proc_reset/proc_enter/proc_input : drive side of the Processor
//   proc_halt/proc_output    : completion flag and result from the Processor
// Modport slave is the host driver; modport master is its environment.
interface gcd_host_driver_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] op_x;
    logic [DATA_W-1:0] op_y;
    logic              busy;
    logic              proc_reset;
    logic              proc_enter;
    logic [DATA_W-1:0] proc_input;
    logic              proc_halt;
    logic [DATA_W-1:0] proc_output;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              error;
    logic              timeout;

    modport slave (
        input  start, op_x, op_y, proc_halt, proc_output,
        output busy, proc_reset, proc_enter, proc_input,
               result, result_valid, error, timeout
    );

    modport master (
        output start, op_x, op_y, proc_halt, proc_output,
        input  busy, proc_reset, proc_enter, proc_input,
               result, result_valid, error, timeout
    );
endinterface

// File: rtl/gcd_host_driver.sv
// Hardware host for the GCD Processor. Accepts one non-zero operand pair per
// start request, pulses the Processor reset, enters X and Y separated by GAP
// idle cycles, waits up to TIMEOUT cycles for halt and returns the result.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gcd_host_driver_if.slave (requester and Processor signals)
// Every output is a register loaded from the same-edge FSM decision, so a
// pulse tied to a transition appears in the cycle after that edge.
module gcd_host_driver #(
    parameter int DATA_W  = 8,
    parameter int GAP     = 15,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    gcd_host_driver_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRST  = 3'd1,
        GAPX  = 3'd2,
        ENTX  = 3'd3,
        GAPY  = 3'd4,
        ENTY  = 3'd5,
        WAITH = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam int                GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [16:0]       TO_LIMIT = 17'(TIMEOUT);

    state_t            state_r;
    state_t            state_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [15:0]       to_cnt_r;
    logic [DATA_W-1:0] op_x_r;
    logic [DATA_W-1:0] op_y_r;

    logic              ops_ok_s;
    logic              to_hit_s;

    logic              busy_r,         busy_s;
    logic              proc_reset_r,   proc_reset_s;
    logic              proc_enter_r,   proc_enter_s;
    logic [DATA_W-1:0] proc_input_r,   proc_input_s;
    logic [DATA_W-1:0] result_r,       result_s;
    logic              result_valid_r, result_valid_s;
    logic              error_r,        error_s;
    logic              timeout_r,      timeout_s;

    assign ops_ok_s = (|bus.op_x) & (|bus.op_y);
    // The count is checked before increment so the limit edge itself aborts.
    assign to_hit_s = (({1'b0, to_cnt_r} + 17'd1) >= TO_LIMIT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start && ops_ok_s) begin
                    state_s = PRST;
                end else begin
                    state_s = IDLE;
                end
            end
            PRST: begin
                if (GAP == 0) begin
                    state_s = ENTX;
                end else begin
                    state_s = GAPX;
                end
            end
            GAPX: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ENTX;
                end else begin
                    state_s = GAPX;
                end
            end
            ENTX: begin
                if (GAP == 0) begin
                    state_s = ENTY;
                end else begin
                    state_s = GAPY;
                end
            end
            GAPY: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ENTY;
                end else begin
                    state_s = GAPY;
                end
            end
            ENTY: state_s = WAITH;
            WAITH: begin
                // Halt wins over a timeout on the same edge.
                if (bus.proc_halt) begin
                    state_s = DONE;
                end else if (to_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAITH;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode, loaded into the output registers on the same edge
    always_comb begin
        busy_s         = (state_s != IDLE);
        proc_reset_s   = (state_s == PRST);
        proc_enter_s   = (state_s == ENTX) || (state_s == ENTY);
        result_valid_s = (state_r == DONE);
        error_s        = (state_r == IDLE) && bus.start && !ops_ok_s;
        timeout_s      = (state_r == WAITH) && !bus.proc_halt && to_hit_s;
        case (state_s)
            ENTX:    proc_input_s = op_x_r;
            ENTY:    proc_input_s = op_y_r;
            default: proc_input_s = proc_input_r;
        endcase
        if ((state_r == WAITH) && bus.proc_halt) begin
            result_s = bus.proc_output;
        end else begin
            result_s = result_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r         <= 1'b0;
            proc_reset_r   <= 1'b0;
            proc_enter_r   <= 1'b0;
            proc_input_r   <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            error_r        <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            busy_r         <= busy_s;
            proc_reset_r   <= proc_reset_s;
            proc_enter_r   <= proc_enter_s;
            proc_input_r   <= proc_input_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
            error_r        <= error_s;
            timeout_r      <= timeout_s;
        end
    end

    // Operand capture on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_x_r <= '0;
            op_y_r <= '0;
        end else if ((state_r == IDLE) && (state_s == PRST)) begin
            op_x_r <= bus.op_x;
            op_y_r <= bus.op_y;
        end else begin
            op_x_r <= op_x_r;
            op_y_r <= op_y_r;
        end
    end

    // Gap counter: runs while a gap state persists, zero everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= '0;
        end else if (((state_r == GAPX) || (state_r == GAPY)) && (state_s == state_r)) begin
            gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Halt wait counter: saturating, zero outside WAITH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 16'd0;
        end else if (state_r == WAITH) begin
            if (to_cnt_r != 16'hFFFF) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end else begin
            to_cnt_r <= 16'd0;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.proc_reset   = proc_reset_r;
    assign bus.proc_enter   = proc_enter_r;
    assign bus.proc_input   = proc_input_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.error        = error_r;
    assign bus.timeout      = timeout_r;
endmodule
